// File: rtl/fsm_ab_pkg.sv
// Shared types for the A/B sequence detector: state encoding and output decode.
package fsm_ab_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ONE_A = 2'b01,
        HOLD  = 2'b10
    } state_t;

    function automatic logic state_is_hold(input state_t s);
        return (s == HOLD);
    endfunction

endpackage

// File: rtl/fsm_ab_seq.sv
// Moore detector: Q rises after A is seen high on two consecutive edges,
// then holds while A or B stays high.
module fsm_ab_seq
    import fsm_ab_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic A,
    input  logic B,
    output logic Q
);

    state_t state_d, state_q;
    logic   q_d, q_q;

    // Q is registered from the next state, so it always equals (state_q == HOLD)
    // without any path from A/B to the output pin.
    always_comb begin
        state_d = IDLE;
        case (state_q)
            IDLE:    state_d = A ? ONE_A : IDLE;
            ONE_A:   state_d = A ? HOLD  : IDLE;
            HOLD:    state_d = (A | B) ? HOLD : IDLE;
            default: state_d = IDLE;
        endcase
        q_d = state_is_hold(state_d);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            q_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
        end
    end

    assign Q = q_q;

endmodule

// File: tb/tb_fsm_ab_seq.sv
// Scoreboard bench for fsm_ab_seq: directed sequences plus random A/B traffic.
module tb_fsm_ab_seq;

    logic clk;
    logic reset;
    logic A;
    logic B;
    logic Q;

    int n_vec  = 0;
    int n_miss = 0;
    bit drv_done = 0;

    bit exp_q[$];
    string exp_name[$];

    // Reference: length of the current run of A-high edges plus a latched detect flag.
    bit m_hold   = 0;
    int m_streak = 0;

    fsm_ab_seq dut (
        .clk   (clk),
        .reset (reset),
        .A     (A),
        .B     (B),
        .Q     (Q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model_reset();
        m_hold   = 0;
        m_streak = 0;
    endfunction

    function automatic void model_edge(input bit a, input bit b);
        if (m_hold) begin
            if (!(a || b)) begin
                m_hold   = 0;
                m_streak = 0;
            end
        end else begin
            m_streak = a ? m_streak + 1 : 0;
            if (m_streak >= 2) m_hold = 1;
        end
    endfunction

    task automatic check(input string name, input bit act, input bit req);
        n_vec++;
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s: Q=%0b expected %0b at %0t", name, act, req, $time);
        end
    endtask

    // Apply inputs for the coming rising edge and queue the expected Q.
    task automatic step(input bit a, input bit b, input bit rst_n, input string name);
        @(negedge clk);
        A = a;
        B = b;
        reset = rst_n;
        if (!rst_n) model_reset();
        else model_edge(a, b);
        exp_q.push_back(m_hold);
        exp_name.push_back(name);
    endtask

    // Same as step, but pulses reset low between edges and checks Q drops at once.
    task automatic step_pulse(input bit a, input bit b, input string name);
        @(negedge clk);
        A = a;
        B = b;
        #2 reset = 1'b0;
        #1 check({name, "_async"}, Q, 1'b0);
        model_reset();
        #1 reset = 1'b1;
        model_edge(a, b);
        exp_q.push_back(m_hold);
        exp_name.push_back(name);
    endtask

    initial begin : monitor
        bit    e;
        string nm;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = exp_name.pop_front();
                check(nm, Q, e);
            end
        end
    end

    initial begin : driver
        A = 1'b1;
        B = 1'b1;
        reset = 1'b0;
        #1 check("reset_t0", Q, 1'b0);

        step(1, 1, 0, "reset_hold");
        step(1, 1, 0, "reset_hold");

        step(1, 0, 1, "detect");
        step(1, 0, 1, "detect");

        for (int i = 0; i < 3; i++) step(0, 1, 1, "hold_b");
        step(0, 0, 1, "drop");

        step(1, 0, 1, "break");
        step(0, 0, 1, "break");
        step(1, 0, 1, "break");
        step(0, 0, 1, "break");

        for (int i = 0; i < 5; i++) step(1, 0, 1, "hold_a");
        step(0, 0, 1, "drop_a");

        step(0, 1, 1, "b_alone");
        step(0, 1, 1, "b_alone");

        step(1, 0, 1, "mid_one_a");
        step_pulse(1, 0, "mid_pulse");
        step(1, 0, 1, "mid_second");
        step(1, 0, 1, "mid_third");

        // Pulse reset while in HOLD as well.
        step_pulse(0, 1, "hold_pulse");
        step(0, 1, 1, "hold_pulse_b");

        for (int i = 0; i < 400; i++) begin
            bit a, b;
            a = ($urandom_range(0, 99) < 60);
            b = ($urandom_range(0, 99) < 40);
            if ($urandom_range(0, 49) == 0) step_pulse(a, b, "rand_pulse");
            else if ($urandom_range(0, 79) == 0) step(a, b, 0, "rand_rst");
            else step(a, b, 1, "rand");
        end

        drv_done = 1;
        for (int t = 0; t < 20 && exp_q.size() > 0; t++) @(posedge clk);
        #2;
        n_vec++;
        if (exp_q.size() != 0) begin
            n_miss++;
            $display("FAIL drain: %0d pending expected %0d", exp_q.size(), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
